// File: rtl/control_ram_write_collector_if.sv
// Beat-in / word-out bus of the control RAM write collector.
// The slave modport is the collector; the master modport is the command side plus RAM port model.
interface control_ram_write_collector_if #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int PIXEL_WIDTH     = 64
);
  // Beat fields are one bit wider than strictly needed so out-of-range values can be presented and rejected
  localparam int ROW_W      = $clog2(PIXEL_HEIGHT + 1);
  localparam int COL_W      = $clog2(PIXEL_WIDTH + 1);
  localparam int PIX_W      = $clog2(BYTES_PER_PIXEL + 1);
  localparam int ADDR_WIDTH = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT);
  localparam int DATA_W     = 8 * BYTES_PER_PIXEL;

  logic [ROW_W-1:0]           row;
  logic [COL_W-1:0]           column;
  logic [PIX_W-1:0]           pixel;
  logic [7:0]                 data_in;
  logic                       ram_write_enable;
  logic                       ram_access_start;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [BYTES_PER_PIXEL-1:0] wr_byte_en;
  logic                       wr_en;
  logic                       wr_ready;

  modport master (
    output row, column, pixel, data_in, ram_write_enable, ram_access_start, wr_ready,
    input  wr_addr, wr_data, wr_byte_en, wr_en
  );

  modport slave (
    input  row, column, pixel, data_in, ram_write_enable, ram_access_start, wr_ready,
    output wr_addr, wr_data, wr_byte_en, wr_en
  );
endinterface

// File: rtl/control_ram_write_collector.sv
// Collects per-byte RAM write beats into pixel words and issues one byte-enabled word write per pixel.
// Beats pass through one input register, so a word completed by the beat sampled at edge N is written after N+1.
module control_ram_write_collector #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int PIXEL_WIDTH     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  control_ram_write_collector_if.slave  bus,
  input  logic                          flush,
  input  logic                          clear_errors,
  output logic                          idle,
  output logic                          overflow,
  output logic                          range_error
);
  localparam int ROW_W      = $clog2(PIXEL_HEIGHT + 1);
  localparam int COL_W      = $clog2(PIXEL_WIDTH + 1);
  localparam int PIX_W      = $clog2(BYTES_PER_PIXEL + 1);
  localparam int ADDR_WIDTH = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT);
  localparam int DATA_W     = 8 * BYTES_PER_PIXEL;

  localparam logic [0:0] ACC_EMPTY   = 1'b0;
  localparam logic [0:0] ACC_PARTIAL = 1'b1;

  logic                       beat_q, start_q, flush_q;
  logic [ROW_W-1:0]           row_q;
  logic [COL_W-1:0]           col_q;
  logic [PIX_W-1:0]           pix_q;
  logic [7:0]                 byte_q;

  logic [0:0]                 acc_state, next_state;
  logic [ROW_W-1:0]           acc_row, commit_row;
  logic [COL_W-1:0]           acc_col, commit_col;
  logic [DATA_W-1:0]          acc_data, base_data, merged_data, commit_data;
  logic [BYTES_PER_PIXEL-1:0] acc_be, base_be, merged_be, commit_be;

  logic                       out_en;
  logic [ADDR_WIDTH-1:0]      out_addr, commit_addr;
  logic [DATA_W-1:0]          out_data;
  logic [BYTES_PER_PIXEL-1:0] out_be;

  logic in_range, valid_beat, bad_beat, is_partial, new_addr, commit, out_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q  <= 1'b0;
      start_q <= 1'b0;
      flush_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      byte_q  <= '0;
    end else begin
      beat_q  <= bus.ram_write_enable;
      start_q <= bus.ram_access_start;
      flush_q <= flush;
      row_q   <= bus.row;
      col_q   <= bus.column;
      pix_q   <= bus.pixel;
      byte_q  <= bus.data_in;
    end
  end

  assign in_range   = (row_q < ROW_W'(PIXEL_HEIGHT)) && (col_q < COL_W'(PIXEL_WIDTH)) &&
                      (pix_q < PIX_W'(BYTES_PER_PIXEL));
  assign valid_beat = beat_q && in_range;
  assign bad_beat   = beat_q && !in_range;
  assign is_partial = (acc_state == ACC_PARTIAL);
  assign new_addr   = valid_beat && is_partial &&
                      (start_q || (row_q != acc_row) || (col_q != acc_col));

  // A beat that opens a new word merges onto an all-zero base so unwritten lanes read back as 0
  always_comb begin
    base_data   = (is_partial && !new_addr) ? acc_data : '0;
    base_be     = (is_partial && !new_addr) ? acc_be : '0;
    merged_data = base_data;
    merged_be   = base_be;
    for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
      if (int'(pix_q) == i) begin
        merged_data[i*8 +: 8] = byte_q;
        merged_be[i]          = 1'b1;
      end
    end
  end

  always_comb begin
    commit      = 1'b0;
    commit_row  = acc_row;
    commit_col  = acc_col;
    commit_data = acc_data;
    commit_be   = acc_be;
    next_state  = acc_state;
    if (new_addr) begin
      commit     = 1'b1;
      next_state = ACC_PARTIAL;
    end else if (valid_beat && (&merged_be)) begin
      commit      = 1'b1;
      commit_row  = row_q;
      commit_col  = col_q;
      commit_data = merged_data;
      commit_be   = merged_be;
      next_state  = ACC_EMPTY;
    end else if (valid_beat) begin
      next_state = ACC_PARTIAL;
    end else if (flush_q && is_partial) begin
      commit     = 1'b1;
      next_state = ACC_EMPTY;
    end
  end

  assign commit_addr = ADDR_WIDTH'(commit_row) * ADDR_WIDTH'(PIXEL_WIDTH) + ADDR_WIDTH'(commit_col);
  assign out_free    = !out_en || bus.wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_state <= ACC_EMPTY;
      acc_row   <= '0;
      acc_col   <= '0;
      acc_data  <= '0;
      acc_be    <= '0;
    end else begin
      acc_state <= next_state;
      if (valid_beat) begin
        acc_row  <= row_q;
        acc_col  <= col_q;
        acc_data <= merged_data;
        acc_be   <= merged_be;
      end
    end
  end

  // Single-entry output slot; a drain and a reload may happen on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_en   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_be   <= '0;
    end else if (commit && out_free) begin
      out_en   <= 1'b1;
      out_addr <= commit_addr;
      out_data <= commit_data;
      out_be   <= commit_be;
    end else if (out_en && bus.wr_ready) begin
      out_en <= 1'b0;
    end
  end

  // A new error in the same cycle as clear_errors wins, so the flag stays set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      range_error <= 1'b0;
    end else begin
      if (clear_errors) begin
        overflow    <= 1'b0;
        range_error <= 1'b0;
      end
      if (commit && !out_free) overflow <= 1'b1;
      if (bad_beat) range_error <= 1'b1;
    end
  end

  assign bus.wr_en      = out_en;
  assign bus.wr_addr    = out_addr;
  assign bus.wr_data    = out_data;
  assign bus.wr_byte_en = out_be;
  assign idle           = (acc_state == ACC_EMPTY) && !out_en && !beat_q;
endmodule

// File: tb/tb_control_ram_write_collector.sv
// Directed bench for control_ram_write_collector with BPP=2, W=64, H=32; inputs change on the falling edge.
module tb_control_ram_write_collector;
  logic clk;
  logic reset;
  logic flush;
  logic clear_errors;
  logic idle;
  logic overflow;
  logic range_error;
  int   check_count;
  int   pass_count;
  logic saw_wr;

  control_ram_write_collector_if #(
    .BYTES_PER_PIXEL(2), .PIXEL_HEIGHT(32), .PIXEL_WIDTH(64)
  ) bus ();

  control_ram_write_collector #(
    .BYTES_PER_PIXEL(2), .PIXEL_HEIGHT(32), .PIXEL_WIDTH(64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flush        (flush),
    .clear_errors (clear_errors),
    .idle         (idle),
    .overflow     (overflow),
    .range_error  (range_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One cycle of inputs: set them after a falling edge, hold through the rising edge, return at the next falling edge
  task automatic applyStimulus(input logic we, input int r, input int c, input int p,
                               input logic [7:0] d, input logic start, input logic fl);
    bus.ram_write_enable = we;
    bus.row              = 6'(r);
    bus.column           = 7'(c);
    bus.pixel            = 2'(p);
    bus.data_in          = d;
    bus.ram_access_start = start;
    flush                = fl;
    @(negedge clk);
  endtask

  task automatic nop();
    applyStimulus(1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulseClear();
    clear_errors = 1'b1;
    nop();
    clear_errors = 1'b0;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset        = 1'b1;
    clear_errors = 1'b0;
    flush        = 1'b0;
    bus.wr_ready = 1'b1;
    bus.ram_write_enable = 1'b0;
    bus.ram_access_start = 1'b0;
    bus.row = '0;
    bus.column = '0;
    bus.pixel = '0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
    checkOutput("rst_idle", 32'(idle), 1);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_range_error", 32'(range_error), 0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 0);
    reset = 1'b0;
    nop();

    // Full pixel: r3*64+5 = 197
    applyStimulus(1'b1, 3, 5, 0, 8'hAA, 1'b1, 1'b0);
    applyStimulus(1'b1, 3, 5, 1, 8'h55, 1'b0, 1'b0);
    checkOutput("t1_not_early", 32'(bus.wr_en), 0);
    nop();
    checkOutput("t1_wr_en", 32'(bus.wr_en), 1);
    checkOutput("t1_addr", 32'(bus.wr_addr), 197);
    checkOutput("t1_data", 32'(bus.wr_data), 32'h55AA);
    checkOutput("t1_be", 32'(bus.wr_byte_en), 32'h3);
    nop();
    checkOutput("t1_single_cycle", 32'(bus.wr_en), 0);
    checkOutput("t1_idle", 32'(idle), 1);

    // Partial pixel flushed: upper lane only
    applyStimulus(1'b1, 0, 0, 1, 8'h12, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2_idle_busy", 32'(idle), 0);
    nop();
    checkOutput("t2_wr_en", 32'(bus.wr_en), 1);
    checkOutput("t2_addr", 32'(bus.wr_addr), 0);
    checkOutput("t2_data", 32'(bus.wr_data), 32'h1200);
    checkOutput("t2_be", 32'(bus.wr_byte_en), 32'h2);
    nop();
    checkOutput("t2_idle", 32'(idle), 1);

    // Address change commits the old partial word
    applyStimulus(1'b1, 1, 0, 0, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1, 0, 8'h02, 1'b0, 1'b0);
    nop();
    checkOutput("t3_wr_en", 32'(bus.wr_en), 1);
    checkOutput("t3_addr", 32'(bus.wr_addr), 64);
    checkOutput("t3_data", 32'(bus.wr_data), 32'h0001);
    checkOutput("t3_be", 32'(bus.wr_byte_en), 32'h1);
    checkOutput("t3_held_partial", 32'(idle), 0);
    applyStimulus(1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b1);
    nop();
    checkOutput("t3_flush_addr", 32'(bus.wr_addr), 65);
    checkOutput("t3_flush_data", 32'(bus.wr_data), 32'h0002);
    nop();

    // Back-pressure: second full word is dropped
    bus.wr_ready = 1'b0;
    applyStimulus(1'b1, 2, 0, 0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 0, 1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1, 0, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1, 1, 8'h44, 1'b0, 1'b0);
    nop();
    checkOutput("t4_overflow", 32'(overflow), 1);
    checkOutput("t4_held_en", 32'(bus.wr_en), 1);
    checkOutput("t4_held_addr", 32'(bus.wr_addr), 128);
    checkOutput("t4_held_data", 32'(bus.wr_data), 32'h2211);
    pulseClear();
    checkOutput("t4_cleared", 32'(overflow), 0);
    bus.wr_ready = 1'b1;
    nop();
    checkOutput("t4_drained", 32'(bus.wr_en), 0);
    checkOutput("t4_idle", 32'(idle), 1);

    // Out-of-range beats are dropped
    applyStimulus(1'b1, 32, 0, 0, 8'hFF, 1'b0, 1'b0);
    nop();
    checkOutput("t5_row_err", 32'(range_error), 1);
    checkOutput("t5_row_idle", 32'(idle), 1);
    pulseClear();
    checkOutput("t5_cleared", 32'(range_error), 0);
    applyStimulus(1'b1, 0, 0, 2, 8'hFF, 1'b0, 1'b0);
    nop();
    checkOutput("t5_pix_err", 32'(range_error), 1);
    nop();
    checkOutput("t5_no_write", 32'(bus.wr_en), 0);
    pulseClear();

    // Async reset with a held write and a partial word
    bus.wr_ready = 1'b0;
    applyStimulus(1'b1, 5, 0, 0, 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 5, 0, 1, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 4, 4, 0, 8'h77, 1'b0, 1'b0);
    nop();
    checkOutput("t6_pre_wr_en", 32'(bus.wr_en), 1);
    checkOutput("t6_pre_idle", 32'(idle), 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_async_wr_en", 32'(bus.wr_en), 0);
    checkOutput("t6_async_addr", 32'(bus.wr_addr), 0);
    checkOutput("t6_async_idle", 32'(idle), 1);
    @(negedge clk);
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    saw_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nop();
      if (bus.wr_en) saw_wr = 1'b1;
    end
    checkOutput("t6_no_write", 32'(saw_wr), 0);
    checkOutput("t6_idle_after", 32'(idle), 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
